// File: rtl/delta_layer_sequencer.sv
// Walks a table of per-layer descriptors in DRAM and drives the Delta_controller one layer at a time.
// Define DELTA_SEQ_PERF_EN to build the last-layer and total busy-cycle counters.
module delta_layer_sequencer #(
  parameter int unsigned DESC_WORDS   = 12,
  parameter int unsigned MAX_LAYERS_W = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    host_start,
  input  logic [31:0]             desc_base,
  input  logic [MAX_LAYERS_W-1:0] layer_count,
  output logic                    busy,
  output logic                    all_done,
  output logic                    err,
  output logic [MAX_LAYERS_W-1:0] layers_done,
  output logic                    dram_owner,
  output logic                    DRAM_Read,
  output logic [31:0]             DRAM_Address,
  input  logic [31:0]             DRAM_ReadData,
  input  logic                    DRAM_DataReady,
  output logic                    start,
  input  logic                    ack,
  input  logic                    done,
  output logic [15:0]             IC_Num,
  output logic [15:0]             OC_Num,
  output logic [15:0]             RC_Size,
  output logic [15:0]             ORC_Size,
  output logic [3:0]              kernel_size,
  output logic [2:0]              stride,
  output logic [15:0]             weight_delta_len,
  output logic [15:0]             weight_num_len,
  output logic [15:0]             idx_delta_len,
  output logic                    load_input,
  output logic                    store_output,
  output logic [31:0]             weight_start_address,
  output logic [31:0]             weight_idx_start_offset,
  output logic [31:0]             weight_unique_start_offset,
  output logic [31:0]             weight_repetition_start_offset,
  output logic [31:0]             bias_start_address,
  output logic [31:0]             input_start_address,
  output logic [31:0]             output_start_address,
  output logic [31:0]             last_layer_cycles,
  output logic [31:0]             total_cycles
);

  localparam int unsigned IdxW        = (DESC_WORDS > 1) ? $clog2(DESC_WORDS) : 1;
  localparam int          ShadowWords = 12;

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StFetchReq  = 3'd1;
  localparam logic [2:0] StFetchWait = 3'd2;
  localparam logic [2:0] StCheck     = 3'd3;
  localparam logic [2:0] StStart     = 3'd4;
  localparam logic [2:0] StRun       = 3'd5;
  localparam logic [2:0] StNext      = 3'd6;
  localparam logic [2:0] StFinish    = 3'd7;

  logic [2:0]              state_q, state_d;
  logic [31:0]             desc_ptr_q;
  logic [IdxW-1:0]         word_idx_q;
  logic [MAX_LAYERS_W-1:0] count_q;
  logic [31:0]             shadow_q [ShadowWords];
  logic [MAX_LAYERS_W-1:0] layers_next;
  logic                    last_word;
  logic                    desc_bad;
  logic                    run_last;
  logic                    unused_shadow;

  assign last_word   = word_idx_q == IdxW'(DESC_WORDS - 1);
  assign layers_next = layers_done + MAX_LAYERS_W'(1);
  assign desc_bad    = (shadow_q[0][15:0] == '0) || (shadow_q[0][31:16] == '0) ||
                       (shadow_q[2][3:0] == '0) || (shadow_q[2][6:4] == '0);
  // layer_count of 0 means the descriptor's last bit alone ends the run
  assign run_last    = shadow_q[2][31] || ((count_q != '0) && (layers_next == count_q));

  // Reserved descriptor bits are fetched but carry no meaning here.
  assign unused_shadow = ^{shadow_q[2][30:10], shadow_q[2][7], shadow_q[4][31:16]};

  assign busy         = (state_q != StIdle) && (state_q != StFinish);
  assign all_done     = state_q == StFinish;
  assign dram_owner   = (state_q == StFetchReq) || (state_q == StFetchWait);
  assign DRAM_Read    = dram_owner;
  assign DRAM_Address = desc_ptr_q + (32'(word_idx_q) << 2);
  assign start        = state_q == StStart;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (host_start) state_d = StFetchReq;
      StFetchReq,
      StFetchWait: begin
        if (DRAM_DataReady) state_d = last_word ? StCheck : StFetchReq;
        else                state_d = StFetchWait;
      end
      StCheck:     state_d = desc_bad ? StFinish : StStart;
      StStart:     if (ack) state_d = StRun;
      StRun:       if (done) state_d = StNext;
      StNext:      state_d = run_last ? StFinish : StFetchReq;
      StFinish:    state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q                        <= StIdle;
      desc_ptr_q                     <= '0;
      word_idx_q                     <= '0;
      count_q                        <= '0;
      err                            <= 1'b0;
      layers_done                    <= '0;
      for (int i = 0; i < ShadowWords; i++) shadow_q[i] <= '0;
      IC_Num                         <= '0;
      OC_Num                         <= '0;
      RC_Size                        <= '0;
      ORC_Size                       <= '0;
      kernel_size                    <= '0;
      stride                         <= '0;
      load_input                     <= 1'b0;
      store_output                   <= 1'b0;
      weight_delta_len               <= '0;
      weight_num_len                 <= '0;
      idx_delta_len                  <= '0;
      weight_start_address           <= '0;
      weight_idx_start_offset        <= '0;
      weight_unique_start_offset     <= '0;
      weight_repetition_start_offset <= '0;
      bias_start_address             <= '0;
      input_start_address            <= '0;
      output_start_address           <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (host_start) begin
            desc_ptr_q  <= desc_base;
            count_q     <= layer_count;
            layers_done <= '0;
            err         <= 1'b0;
            word_idx_q  <= '0;
          end
        end
        StFetchReq,
        StFetchWait: begin
          if (DRAM_DataReady) begin
            for (int i = 0; i < ShadowWords; i++) begin
              if (int'(word_idx_q) == i) shadow_q[i] <= DRAM_ReadData;
            end
            if (!last_word) word_idx_q <= word_idx_q + IdxW'(1);
          end
        end
        StCheck: begin
          if (desc_bad) begin
            err <= 1'b1;
          end else begin
            IC_Num                         <= shadow_q[0][15:0];
            OC_Num                         <= shadow_q[0][31:16];
            RC_Size                        <= shadow_q[1][15:0];
            ORC_Size                       <= shadow_q[1][31:16];
            kernel_size                    <= shadow_q[2][3:0];
            stride                         <= shadow_q[2][6:4];
            load_input                     <= shadow_q[2][8];
            store_output                   <= shadow_q[2][9];
            weight_delta_len               <= shadow_q[3][15:0];
            weight_num_len                 <= shadow_q[3][31:16];
            idx_delta_len                  <= shadow_q[4][15:0];
            weight_start_address           <= shadow_q[5];
            weight_idx_start_offset        <= shadow_q[6];
            weight_unique_start_offset     <= shadow_q[7];
            weight_repetition_start_offset <= shadow_q[8];
            bias_start_address             <= shadow_q[9];
            input_start_address            <= shadow_q[10];
            output_start_address           <= shadow_q[11];
          end
        end
        StNext: begin
          layers_done <= layers_next;
          if (!run_last) begin
            desc_ptr_q <= desc_ptr_q + 32'(4 * DESC_WORDS);
            word_idx_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DELTA_SEQ_PERF_EN
  logic [31:0] layer_cyc_q;

  // Layer count spans START entry through the done cycle; both counters saturate.
  always_ff @(posedge clock) begin
    if (reset) begin
      layer_cyc_q       <= '0;
      last_layer_cycles <= '0;
      total_cycles      <= '0;
    end else begin
      if (state_q == StCheck) begin
        layer_cyc_q <= '0;
      end else if (((state_q == StStart) || (state_q == StRun)) && (layer_cyc_q != '1)) begin
        layer_cyc_q <= layer_cyc_q + 32'd1;
      end
      if (state_q == StNext) last_layer_cycles <= layer_cyc_q;
      if ((state_q == StIdle) && host_start) begin
        total_cycles <= '0;
      end else if (busy && (total_cycles != '1)) begin
        total_cycles <= total_cycles + 32'd1;
      end
    end
  end
`else
  assign last_layer_cycles = '0;
  assign total_cycles      = '0;
`endif

endmodule
